// File: rtl/branch_offset_pack.sv
// Packs a branch target into a 16-bit word-offset immediate relative to pc + PC_INC.
// Three-state handshake: IDLE accepts, CALC computes, DONE holds the result.
module branch_offset_pack #(
    parameter int PC_INC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc,
    input  logic [31:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] imm,
    output logic        misaligned,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] INC = 32'(PC_INC);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [15:0] imm_q, imm_d;
    logic        mis_q, mis_d;
    logic        ovf_q, ovf_d;
    logic [31:0] diff;

    // Plain 32-bit wrap-around; only the upper sign bits decide overflow.
    always_comb begin
        diff = tgt_q - (pc_q + INC);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        imm_d   = imm_q;
        mis_d   = mis_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pc_d    = pc;
                    tgt_d   = target;
                    state_d = CALC;
                end
            end
            CALC: begin
                imm_d   = diff[17:2];
                mis_d   = |diff[1:0];
                ovf_d   = !((&diff[31:17]) || !(|diff[31:17]));
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            tgt_q   <= '0;
            imm_q   <= '0;
            mis_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            imm_q   <= imm_d;
            mis_q   <= mis_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign imm        = imm_q;
    assign misaligned = mis_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_branch_offset_pack.sv
// Directed bench for branch_offset_pack with hand-computed vectors.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_branch_offset_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm;
    logic        misaligned;
    logic        overflow;

    int checks;
    int errors;

    branch_offset_pack #(.PC_INC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .misaligned(misaligned),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, check CALC cycle, check DONE, release.
    task automatic run_req(input string tag, input logic [31:0] p,
                           input logic [31:0] t, input logic [15:0] e_imm,
                           input logic e_mis, input logic e_ovf);
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        pc       = p;
        target   = t;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, ".calc_vld"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".calc_rdy"}, {31'b0, in_ready}, 32'd0);
        step();
        chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".imm"}, {16'b0, imm}, {16'b0, e_imm});
        chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, e_mis});
        chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, e_ovf});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".hold_imm"}, {16'b0, imm}, {16'b0, e_imm});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pc        = '0;
        target    = '0;
        step();
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.imm", {16'b0, imm}, 32'd0);
        chk("rst.flags", {30'b0, misaligned, overflow}, 32'd0);
        rst = 1'b0;
        step();

        run_req("fwd",  32'h0040_0000, 32'h0040_0010, 16'h0003, 1'b0, 1'b0);
        run_req("bwd",  32'h0040_0010, 32'h0040_0000, 16'hFFFB, 1'b0, 1'b0);
        run_req("max",  32'h0000_0000, 32'h0002_0000, 16'h7FFF, 1'b0, 1'b0);
        run_req("over", 32'h0000_0000, 32'h0002_0004, 16'h8000, 1'b0, 1'b1);
        run_req("min",  32'h0000_0000, 32'hFFFE_0004, 16'h8000, 1'b0, 1'b0);
        run_req("mis",  32'h0000_1000, 32'h0000_1006, 16'h0000, 1'b1, 1'b0);
        run_req("wrap", 32'hFFFF_FFFC, 32'h0000_0004, 16'h0001, 1'b0, 1'b0);
        run_req("both", 32'h0000_0000, 32'h0002_0007, 16'h8000, 1'b1, 1'b1);

        // Stall: consumer not ready for 5 cycles, extra in_valid ignored.
        pc       = 32'h0000_0100;
        target   = 32'h0000_0080;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        pc       = 32'h0000_0000;
        target   = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            chk("stall.valid", {31'b0, out_valid}, 32'd1);
            chk("stall.rdy", {31'b0, in_ready}, 32'd0);
            chk("stall.imm", {16'b0, imm}, 32'h0000_FFDF);
            chk("stall.flags", {30'b0, misaligned, overflow}, 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall.release", {31'b0, out_valid}, 32'd0);
        chk("stall.idle", {31'b0, in_ready}, 32'd1);

        // Consumer already ready: exactly one valid cycle.
        pc        = 32'h0000_0000;
        target    = 32'h0000_0008;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre.valid", {31'b0, out_valid}, 32'd1);
        chk("pre.imm", {16'b0, imm}, 32'h0000_0001);
        step();
        chk("pre.one", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset in CALC aborts the request.
        pc       = 32'h0000_0000;
        target   = 32'h0000_0100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("abort.async_rdy", {31'b0, in_ready}, 32'd1);
        chk("abort.imm", {16'b0, imm}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort.no_valid", {31'b0, out_valid}, 32'd0);
            chk("abort.outs", {14'b0, imm, misaligned, overflow}, 32'd0);
            step();
        end
        run_req("after", 32'h0040_0000, 32'h0040_0010, 16'h0003, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
